// File: rtl/blob_tracker_pkg.sv
// Shared types and widths for the multi-channel colour blob tracker.
// Coordinates are 10 bits, frame hit counts 19 bits.
package blob_tracker_pkg;

   typedef enum logic [1:0] {
      DOM_R   = 2'd0,
      DOM_G   = 2'd1,
      DOM_B   = 2'd2,
      DOM_OFF = 2'd3
   } dom_t;

   localparam int COORD_W = 10;
   localparam int CNT_W   = 19;
   localparam int RUN_W   = 5;
   localparam int MISS_W  = 4;
   localparam int COL_W   = 4;

   localparam logic [CNT_W-1:0]   CNT_MAX       = '1;
   localparam logic [COORD_W-1:0] BOX_MAX_EMPTY = '0;

   // Midpoint without losing the carry of the sum.
   function automatic logic [COORD_W-1:0] mid(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b);
      logic [COORD_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[COORD_W:1];
   endfunction

endpackage

// File: rtl/blob_channel.sv
// One colour channel: classifier, run-length debounce, per-frame bounding
// box and the accept/miss bookkeeping that drives the published result.
module blob_channel
   import blob_tracker_pkg::*;
#(
   parameter int RUN_LEN     = 8,
   parameter int MIN_SPAN    = 10,
   parameter int LOST_FRAMES = 4,
   parameter int SMOOTH      = 0,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               href,
   input  logic [COL_W-1:0]   r_in,
   input  logic [COL_W-1:0]   g_in,
   input  logic [COL_W-1:0]   b_in,
   input  logic [1:0]         dom,
   input  logic [COL_W-1:0]   min_bright,
   input  logic [COL_W-1:0]   margin,
   input  logic [COL_W-1:0]   max_other,
   input  logic               href_d,
   input  logic [COORD_W-1:0] x_d,
   input  logic [COORD_W-1:0] y_d,
   input  logic               frame_end,
   output logic [COORD_W-1:0] center_x,
   output logic [COORD_W-1:0] center_y,
   output logic [CNT_W-1:0]   hit_count,
   output logic               blob_valid
);

   localparam logic [RUN_W-1:0]   RUN_SAT  = RUN_W'(RUN_LEN);
   localparam logic [MISS_W-1:0]  LOST_LIM = MISS_W'(LOST_FRAMES);
   localparam logic [COORD_W:0]   SPAN     = (COORD_W+1)'(MIN_SPAN);
   localparam logic [COORD_W-1:0] X_EMPTY  = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_EMPTY  = COORD_W'(V_RES - 1);

   logic [4:0] r5, g5, b5, mb, mg, mo;
   logic [4:0] d, o1, o2;
   logic       hit, hit_d;

   assign r5 = {1'b0, r_in};
   assign g5 = {1'b0, g_in};
   assign b5 = {1'b0, b_in};
   assign mb = {1'b0, min_bright};
   assign mg = {1'b0, margin};
   assign mo = {1'b0, max_other};

   // Five-bit arithmetic so component + margin never wraps.
   always_comb begin
      d  = '0;
      o1 = '0;
      o2 = '0;
      case (dom_t'(dom))
         DOM_R: begin d = r5; o1 = g5; o2 = b5; end
         DOM_G: begin d = g5; o1 = r5; o2 = b5; end
         DOM_B: begin d = b5; o1 = r5; o2 = g5; end
         default: ;
      endcase
      hit = href && (dom_t'(dom) != DOM_OFF) && (d > mb) &&
            (d > o1 + mg) && (d > o2 + mg) && (o1 < mo) && (o2 < mo);
   end

   logic [RUN_W-1:0]   run;
   logic [RUN_W:0]     run_inc;
   logic               count_px;
   logic [COORD_W-1:0] x_min, x_max, y_min, y_max;
   logic [CNT_W-1:0]   cnt;
   logic [MISS_W-1:0]  miss, miss_inc;
   logic [COORD_W-1:0] raw_x, raw_y;
   logic               accept;

   assign run_inc  = {1'b0, run} + (RUN_W+1)'(1);
   assign count_px = hit_d && (run_inc >= {1'b0, RUN_SAT});
   assign miss_inc = (miss == '1) ? miss : miss + MISS_W'(1);
   assign raw_x    = mid(x_min, x_max);
   assign raw_y    = mid(y_min, y_max);
   assign accept   = ({1'b0, x_max} > {1'b0, x_min} + SPAN) &&
                     ({1'b0, y_max} > {1'b0, y_min} + SPAN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_d      <= 1'b0;
         run        <= '0;
         x_min      <= X_EMPTY;
         x_max      <= BOX_MAX_EMPTY;
         y_min      <= Y_EMPTY;
         y_max      <= BOX_MAX_EMPTY;
         cnt        <= '0;
         miss       <= '0;
         center_x   <= '0;
         center_y   <= '0;
         hit_count  <= '0;
         blob_valid <= 1'b0;
      end else begin
         hit_d <= hit;
         if (!href_d || !hit_d)
            run <= '0;
         else if (run < RUN_SAT)
            run <= run + RUN_W'(1);

         // Frame end takes priority: a pixel landing on it is dropped.
         if (frame_end) begin
            x_min <= X_EMPTY;
            x_max <= BOX_MAX_EMPTY;
            y_min <= Y_EMPTY;
            y_max <= BOX_MAX_EMPTY;
            cnt   <= '0;
            if (accept) begin
               if (SMOOTH != 0 && blob_valid) begin
                  center_x <= mid(center_x, raw_x);
                  center_y <= mid(center_y, raw_y);
               end else begin
                  center_x <= raw_x;
                  center_y <= raw_y;
               end
               hit_count  <= cnt;
               blob_valid <= 1'b1;
               miss       <= '0;
            end else begin
               miss <= miss_inc;
               if (miss_inc >= LOST_LIM)
                  blob_valid <= 1'b0;
            end
         end else if (count_px) begin
            if (x_d < x_min) x_min <= x_d;
            if (x_d > x_max) x_max <= x_d;
            if (y_d < y_min) y_min <= y_d;
            if (y_d > y_max) y_max <= y_d;
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/color_blob_tracker.sv
// Multi-channel colour blob tracker top: vsync edge detection, shared
// stage-1 pixel registers, frame strobe and NUM_CH channel instances.
module color_blob_tracker
   import blob_tracker_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int RUN_LEN     = 8,
   parameter int MIN_SPAN    = 10,
   parameter int LOST_FRAMES = 4,
   parameter int SMOOTH      = 0,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      vsync,
   input  logic                      href,
   input  logic [9:0]                pixel_x,
   input  logic [9:0]                pixel_y,
   input  logic [3:0]                r_in,
   input  logic [3:0]                g_in,
   input  logic [3:0]                b_in,
   input  logic [2*NUM_CH-1:0]       cfg_dom,
   input  logic [4*NUM_CH-1:0]       cfg_min_bright,
   input  logic [4*NUM_CH-1:0]       cfg_margin,
   input  logic [4*NUM_CH-1:0]       cfg_max_other,
   output logic [10*NUM_CH-1:0]      center_x,
   output logic [10*NUM_CH-1:0]      center_y,
   output logic [19*NUM_CH-1:0]      hit_count,
   output logic [NUM_CH-1:0]         blob_valid,
   output logic                      frame_strobe
);

   logic               vsync_d, frame_end, href_d;
   logic [COORD_W-1:0] x_d, y_d;

   // frame_end is registered so results land one edge after detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_d      <= 1'b0;
         frame_end    <= 1'b0;
         frame_strobe <= 1'b0;
         href_d       <= 1'b0;
         x_d          <= '0;
         y_d          <= '0;
      end else begin
         vsync_d      <= vsync;
         frame_end    <= vsync_d & ~vsync;
         frame_strobe <= frame_end;
         href_d       <= href;
         x_d          <= pixel_x;
         y_d          <= pixel_y;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      blob_channel #(
         .RUN_LEN     (RUN_LEN),
         .MIN_SPAN    (MIN_SPAN),
         .LOST_FRAMES (LOST_FRAMES),
         .SMOOTH      (SMOOTH),
         .H_RES       (H_RES),
         .V_RES       (V_RES)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .href        (href),
         .r_in        (r_in),
         .g_in        (g_in),
         .b_in        (b_in),
         .dom         (cfg_dom[2*c +: 2]),
         .min_bright  (cfg_min_bright[4*c +: 4]),
         .margin      (cfg_margin[4*c +: 4]),
         .max_other   (cfg_max_other[4*c +: 4]),
         .href_d      (href_d),
         .x_d         (x_d),
         .y_d         (y_d),
         .frame_end   (frame_end),
         .center_x    (center_x[COORD_W*c +: COORD_W]),
         .center_y    (center_y[COORD_W*c +: COORD_W]),
         .hit_count   (hit_count[CNT_W*c +: CNT_W]),
         .blob_valid  (blob_valid[c])
      );
   end

endmodule
